// File: rtl/block_stack_tracker.sv
// block_stack_tracker
// Keeps the full stack of placed rows for the block stacker. Each accepted
// player stop is intersected with the current top row; on a hit the trimmed
// block is pushed, on a miss the game ends. The renderer reads rows through a
// registered read port.
// Optional feature: define BLOCK_SNAP_EN to snap near-perfect stops onto the
// top row (within SNAP_TOL pixels on both edges) and flag result_perfect.
module block_stack_tracker #(
  parameter int COORD_W    = 9,
  parameter int DEPTH      = 16,
  parameter int BASE_START = 120,
  parameter int BASE_END   = 199,
  parameter int SNAP_TOL   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stop_valid,
  output logic                       stop_ready,
  input  logic [COORD_W-1:0]         curr_start,
  input  logic [COORD_W-1:0]         curr_end,
  output logic [COORD_W-1:0]         top_start,
  output logic [COORD_W-1:0]         top_end,
  output logic [COORD_W-1:0]         top_width,
  output logic [$clog2(DEPTH+1)-1:0] height,
  output logic                       result_valid,
  output logic                       result_hit,
  output logic                       result_perfect,
  output logic                       game_over,
  output logic                       game_won,
  input  logic [$clog2(DEPTH)-1:0]   rd_row,
  output logic [COORD_W-1:0]         rd_start,
  output logic [COORD_W-1:0]         rd_end,
  output logic                       rd_vld
);

  localparam int H_W = $clog2(DEPTH+1);
  localparam int R_W = $clog2(DEPTH);

`ifdef BLOCK_SNAP_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PUSH, S_REPORT, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] cs_q, ce_q, lo_q, hi_q;
  logic               hit_q, perfect_q;
  logic [H_W-1:0]     height_q;
  logic [COORD_W-1:0] row_start_q [DEPTH];
  logic [COORD_W-1:0] row_end_q   [DEPTH];
  logic               game_over_q, game_won_q;
  logic [COORD_W-1:0] rd_start_q, rd_end_q;
  logic               rd_vld_q;

  logic [R_W-1:0]     top_idx, push_idx;
  logic [COORD_W-1:0] lo, hi, d_start, d_end;
  logic               hit, snap, at_full;

  // The top row is always the last pushed one; the next push lands just above it.
  assign top_idx   = R_W'(height_q - H_W'(1));
  assign push_idx  = R_W'(height_q);
  assign top_start = row_start_q[top_idx];
  assign top_end   = row_end_q[top_idx];
  assign top_width = top_end - top_start + COORD_W'(1);
  assign height    = height_q;
  assign at_full   = (height_q == H_W'(DEPTH));
  assign game_over = game_over_q;
  assign game_won  = game_won_q;
  assign rd_start  = rd_start_q;
  assign rd_end    = rd_end_q;
  assign rd_vld    = rd_vld_q;

  // Overlap of the captured block with the top row, plus the snap decision.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
    lo      = (cs_q > top_start) ? cs_q : top_start;
    hi      = (ce_q < top_end) ? ce_q : top_end;
    hit     = (cs_q <= ce_q) && (lo <= hi);
    d_start = (cs_q >= top_start) ? (cs_q - top_start) : (top_start - cs_q);
    d_end   = (ce_q >= top_end) ? (ce_q - top_end) : (top_end - ce_q);
    snap    = SNAP_EN && hit &&
              (d_start <= COORD_W'(SNAP_TOL)) && (d_end <= COORD_W'(SNAP_TOL));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d        = state_q;
    stop_ready     = 1'b0;
    result_valid   = 1'b0;
    result_hit     = 1'b0;
    result_perfect = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_ready = 1'b1;
        if (stop_valid) state_d = S_CHECK;
      end
      S_CHECK: state_d = S_PUSH;
      S_PUSH:  state_d = S_REPORT;
      S_REPORT: begin
        result_valid   = 1'b1;
        result_hit     = hit_q;
        result_perfect = perfect_q;
        if (!hit_q || at_full) state_d = S_OVER;
        else                   state_d = S_IDLE;
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture, intersect, push and game flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the row memory is reset because the renderer and the game rely on a known base row and empty rows.
      for (int i = 0; i < DEPTH; i++) begin
        row_start_q[i] <= '0;
        row_end_q[i]   <= '0;
      end
      row_start_q[0] <= COORD_W'(BASE_START);
      row_end_q[0]   <= COORD_W'(BASE_END);
      height_q       <= H_W'(1);
      cs_q           <= '0;
      ce_q           <= '0;
      lo_q           <= '0;
      hi_q           <= '0;
      hit_q          <= 1'b0;
      perfect_q      <= 1'b0;
      game_over_q    <= 1'b0;
      game_won_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stop_valid) begin
            cs_q <= curr_start;
            ce_q <= curr_end;
          end
        end
        S_CHECK: begin
          lo_q      <= lo;
          hi_q      <= hi;
          hit_q     <= hit;
          perfect_q <= snap;
        end
        S_PUSH: begin
          if (hit_q) begin
            row_start_q[push_idx] <= perfect_q ? top_start : lo_q;
            row_end_q[push_idx]   <= perfect_q ? top_end : hi_q;
            height_q              <= height_q + H_W'(1);
          end
        end
        S_REPORT: begin
          if (!hit_q)      game_over_q <= 1'b1;
          else if (at_full) game_won_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered renderer read port; rows at or above height read as empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_start_q <= '0;
      rd_end_q   <= '0;
      rd_vld_q   <= 1'b0;
    end else if (H_W'(rd_row) < height_q) begin
      rd_start_q <= row_start_q[rd_row];
      rd_end_q   <= row_end_q[rd_row];
      rd_vld_q   <= 1'b1;
    end else begin
      rd_start_q <= '0;
      rd_end_q   <= '0;
      rd_vld_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_stack_tracker.sv
// Testbench for block_stack_tracker: two instances (DEPTH=16 and DEPTH=4)
// driven with identical stops and checked against a queue-based stack model.
module tb_block_stack_tracker;

  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset, stop_valid;
  logic [CW-1:0] curr_start, curr_end;
  logic [3:0]    rd_row_a;
  logic [1:0]    rd_row_b;

  logic          a_ready, a_rv, a_rh, a_rp, a_go, a_gw, a_rdv;
  logic [CW-1:0] a_ts, a_te, a_tw, a_rds, a_rde;
  logic [4:0]    a_height;
  logic          b_ready, b_rv, b_rh, b_rp, b_go, b_gw, b_rdv;
  logic [CW-1:0] b_ts, b_te, b_tw, b_rds, b_rde;
  logic [2:0]    b_height;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  block_stack_tracker dut_a (
    .clk(clk), .reset(reset), .stop_valid(stop_valid), .stop_ready(a_ready),
    .curr_start(curr_start), .curr_end(curr_end),
    .top_start(a_ts), .top_end(a_te), .top_width(a_tw), .height(a_height),
    .result_valid(a_rv), .result_hit(a_rh), .result_perfect(a_rp),
    .game_over(a_go), .game_won(a_gw),
    .rd_row(rd_row_a), .rd_start(a_rds), .rd_end(a_rde), .rd_vld(a_rdv)
  );

  block_stack_tracker #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .stop_valid(stop_valid), .stop_ready(b_ready),
    .curr_start(curr_start), .curr_end(curr_end),
    .top_start(b_ts), .top_end(b_te), .top_width(b_tw), .height(b_height),
    .result_valid(b_rv), .result_hit(b_rh), .result_perfect(b_rp),
    .game_over(b_go), .game_won(b_gw),
    .rd_row(rd_row_b), .rd_start(b_rds), .rd_end(b_rde), .rd_vld(b_rdv)
  );

  typedef struct {
    logic [31:0] ready, ts, te, tw, height, rv, rh, rp, go, gw, rds, rde, rdv;
  } obs_t;

  // Reference model: one queue of rows per instance, plus sticky flags.
  int rs [2][$];
  int re [2][$];
  int m_over [2];
  int m_won  [2];

  function automatic int depth_of(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic obs_t sample(int k);
    obs_t o;
    if (k == 0) begin
      o.ready = 32'(a_ready); o.ts = 32'(a_ts); o.te = 32'(a_te); o.tw = 32'(a_tw);
      o.height = 32'(a_height); o.rv = 32'(a_rv); o.rh = 32'(a_rh); o.rp = 32'(a_rp);
      o.go = 32'(a_go); o.gw = 32'(a_gw); o.rds = 32'(a_rds); o.rde = 32'(a_rde);
      o.rdv = 32'(a_rdv);
    end else begin
      o.ready = 32'(b_ready); o.ts = 32'(b_ts); o.te = 32'(b_te); o.tw = 32'(b_tw);
      o.height = 32'(b_height); o.rv = 32'(b_rv); o.rh = 32'(b_rh); o.rp = 32'(b_rp);
      o.go = 32'(b_go); o.gw = 32'(b_gw); o.rds = 32'(b_rds); o.rde = 32'(b_rde);
      o.rdv = 32'(b_rdv);
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rs[k].delete(); re[k].delete();
      rs[k].push_back(120); re[k].push_back(199);
      m_over[k] = 0; m_won[k] = 0;
    end
  endtask

  // Applies the game rules to one stop; returns whether it is accepted and the result.
  task automatic model_stop(input int k, input int s, input int e,
                            output int acc, output int hit, output int perf);
    int ts, te, lo, hi;
    acc  = (m_over[k] == 0 && m_won[k] == 0) ? 1 : 0;
    hit  = 0;
    perf = 0;
    if (acc == 1) begin
      ts = rs[k][rs[k].size()-1];
      te = re[k][re[k].size()-1];
      lo = (s > ts) ? s : ts;
      hi = (e < te) ? e : te;
      hit = (s <= e && lo <= hi) ? 1 : 0;
`ifdef BLOCK_SNAP_EN
      if (hit == 1 && ((s > ts) ? s - ts : ts - s) <= 1 && ((e > te) ? e - te : te - e) <= 1)
        perf = 1;
`endif
      if (hit == 1) begin
        rs[k].push_back((perf == 1) ? ts : lo);
        re[k].push_back((perf == 1) ? te : hi);
        if (rs[k].size() == depth_of(k)) m_won[k] = 1;
      end else begin
        m_over[k] = 1;
      end
    end
  endtask

  task automatic check_top(input int k, input string tag, input int full);
    obs_t o;
    int sz, ts, te;
    o  = sample(k);
    sz = rs[k].size();
    ts = rs[k][sz-1];
    te = re[k][sz-1];
    check($sformatf("%s/i%0d/height", tag, k), o.height, sz);
    check($sformatf("%s/i%0d/top_start", tag, k), o.ts, ts);
    check($sformatf("%s/i%0d/top_end", tag, k), o.te, te);
    check($sformatf("%s/i%0d/top_width", tag, k), o.tw, te - ts + 1);
    if (full == 1) begin
      check($sformatf("%s/i%0d/game_over", tag, k), o.go, m_over[k]);
      check($sformatf("%s/i%0d/game_won", tag, k), o.gw, m_won[k]);
      check($sformatf("%s/i%0d/stop_ready", tag, k), o.ready,
            (m_over[k] == 0 && m_won[k] == 0) ? 1 : 0);
    end
  endtask

  // Starts and ends just after a falling edge; checks the full 4-cycle window.
  task automatic do_stop(input int s, input int e, input string tag);
    int acc [2];
    int hit [2];
    int perf [2];
    obs_t o;
    curr_start = CW'(s);
    curr_end   = CW'(e);
    stop_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      o = sample(k);
      check($sformatf("%s/i%0d/ready_pre", tag, k), o.ready,
            (m_over[k] == 0 && m_won[k] == 0) ? 1 : 0);
      model_stop(k, s, e, acc[k], hit[k], perf[k]);
    end
    @(posedge clk);
    #1 stop_valid = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        o = sample(k);
        check($sformatf("%s/i%0d/c%0d/result_valid", tag, k, cyc), o.rv,
              (acc[k] == 1 && cyc == 3) ? 1 : 0);
        if (cyc < 4)
          check($sformatf("%s/i%0d/c%0d/stop_ready", tag, k, cyc), o.ready, 0);
        if (cyc == 3 && acc[k] == 1) begin
          check($sformatf("%s/i%0d/result_hit", tag, k), o.rh, hit[k]);
          check($sformatf("%s/i%0d/result_perfect", tag, k), o.rp, perf[k]);
          check_top(k, $sformatf("%s/c3", tag), 0);
        end
        if (cyc == 4) check_top(k, tag, 1);
      end
    end
  endtask

  task automatic rd_check(input int ra, input int rb, input string tag);
    obs_t o;
    int row, vld;
    rd_row_a = 4'(ra);
    rd_row_b = 2'(rb);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      o   = sample(k);
      row = (k == 0) ? ra : rb;
      vld = (row < rs[k].size()) ? 1 : 0;
      check($sformatf("%s/i%0d/rd_vld", tag, k), o.rdv, vld);
      check($sformatf("%s/i%0d/rd_start", tag, k), o.rds, (vld == 1) ? rs[k][row] : 0);
      check($sformatf("%s/i%0d/rd_end", tag, k), o.rde, (vld == 1) ? re[k][row] : 0);
    end
  endtask

  task automatic do_reset(input string tag);
    obs_t o;
    reset      = 1'b1;
    stop_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      o = sample(k);
      check($sformatf("%s/i%0d/rv_in_reset", tag, k), o.rv, 0);
      check($sformatf("%s/i%0d/rd_vld_in_reset", tag, k), o.rdv, 0);
      check($sformatf("%s/i%0d/rd_start_in_reset", tag, k), o.rds, 0);
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) check_top(k, tag, 1);
  endtask

  initial begin
    int k0, ts, te, s, e, r;
    reset      = 1'b1;
    stop_valid = 1'b0;
    curr_start = '0;
    curr_end   = '0;
    rd_row_a   = '0;
    rd_row_b   = '0;

    // Reset state, then a trimming hit and a read of the new row.
    do_reset("reset");
    do_stop(130, 209, "hit_trim");
    rd_check(1, 1, "rd_row1");
    rd_check(2, 2, "rd_row2_empty");

    // Miss ends the game; later stops are ignored.
    do_stop(0, 50, "miss");
    do_stop(130, 199, "after_over");
    do_stop(140, 150, "after_over2");

    // Exact stacking: DEPTH=4 instance wins on the third stop.
    do_reset("reset_win");
    do_stop(120, 199, "exact1");
    do_stop(120, 199, "exact2");
    do_stop(120, 199, "exact3");
    rd_check(3, 3, "rd_row3");
    do_stop(120, 199, "after_won");

    // Near-perfect stop: snapped or trimmed depending on the build.
    do_reset("reset_snap");
    do_stop(130, 209, "snap_setup");
    do_stop(131, 200, "snap");

    // Touching edge and inverted input.
    do_reset("reset_touch");
    do_stop(40, 120, "touch");
    do_reset("reset_inv");
    do_stop(150, 130, "inverted");

    // Reset while the stop is in CHECK: no result, stack back to base.
    do_reset("reset_mid");
    do_stop(130, 209, "mid_setup");
    curr_start = CW'(125);
    curr_end   = CW'(190);
    stop_valid = 1'b1;
    @(posedge clk);
    #1 stop_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      check($sformatf("mid_abort/c%0d/i0/result_valid", cyc), 32'(a_rv), 0);
      check($sformatf("mid_abort/c%0d/i1/result_valid", cyc), 32'(b_rv), 0);
    end
    for (int k = 0; k < 2; k++) check_top(k, "mid_abort", 1);
    rd_check(1, 1, "mid_abort_rd1");

    // Random games biased toward near-hits.
    do_reset("reset_rand");
    for (int it = 0; it < 160; it++) begin
      if ((m_over[0] == 1 || m_won[0] == 1) && (m_over[1] == 1 || m_won[1] == 1))
        do_reset($sformatf("rand_reset%0d", it));
      k0 = (m_over[0] == 1 || m_won[0] == 1) ? 1 : 0;
      ts = rs[k0][rs[k0].size()-1];
      te = re[k0][re[k0].size()-1];
      r  = int'($urandom_range(0, 9));
      if (r == 0) begin
        s = int'($urandom_range(0, 511));
        e = int'($urandom_range(0, 511));
      end else if (r < 5) begin
        s = ts;
        e = te;
      end else begin
        s = ts + int'($urandom_range(0, 4)) - 2;
        e = te + int'($urandom_range(0, 4)) - 2;
        if (s < 0) s = 0;
        if (e > 511) e = 511;
      end
      do_stop(s, e, $sformatf("rand%0d", it));
      rd_check(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               $sformatf("rand_rd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
